// File: rtl/exers_sched_pkg.sv
// exers_sched_pkg: shared definitions for the execute issue scheduler.
//   NENT_DEF / IDXW_DEF : default RS entry count and entry index width
//   NPOOL / NSLOT       : two unit pools (SC, MC), two issue slots each
//   SL_*                : issue slot numbering (slot = 2*pool + unit)
//   unit_cls_e          : unit class of an RS entry (SC = 0, MC = 1)
package exers_sched_pkg;

    localparam int NENT_DEF = 8;
    localparam int IDXW_DEF = 3;

    localparam int NPOOL = 2;
    localparam int NSLOT = 4;

    localparam int SL_SC0 = 0;
    localparam int SL_SC1 = 1;
    localparam int SL_MC0 = 2;
    localparam int SL_MC1 = 3;

    typedef enum logic {
        UC_SC = 1'b0,
        UC_MC = 1'b1
    } unit_cls_e;

endpackage

// File: rtl/exers_sched_if.sv
// exers_sched_if: bundle between rename / RS storage / execute units and
// the issue scheduler.
//   alloc_valid/alloc_idx : RS entry written this cycle
//   ent_ready/ent_mc      : per-entry operand-ready and needs-mcalu flags
//   rob_flush             : drop every entry and issue slot
//   *_stall               : unit cannot accept its slot this cycle
//   sched_*_issue/_idx    : registered issue slots, one per unit
//   sched_free            : entries released at the previous edge
// master = rename/RS/units side, slave = scheduler.
interface exers_sched_if #(
    parameter int NENT = exers_sched_pkg::NENT_DEF,
    parameter int IDXW = exers_sched_pkg::IDXW_DEF
) ();

    logic            alloc_valid;
    logic [IDXW-1:0] alloc_idx;
    logic [NENT-1:0] ent_ready;
    logic [NENT-1:0] ent_mc;
    logic            rob_flush;

    logic            scalu0_stall;
    logic            scalu1_stall;
    logic            mcalu0_stall;
    logic            mcalu1_stall;

    logic            sched_scalu0_issue;
    logic            sched_scalu1_issue;
    logic            sched_mcalu0_issue;
    logic            sched_mcalu1_issue;
    logic [IDXW-1:0] sched_scalu0_idx;
    logic [IDXW-1:0] sched_scalu1_idx;
    logic [IDXW-1:0] sched_mcalu0_idx;
    logic [IDXW-1:0] sched_mcalu1_idx;
    logic [NENT-1:0] sched_free;

    modport master (
        output alloc_valid, alloc_idx, ent_ready, ent_mc, rob_flush,
        output scalu0_stall, scalu1_stall, mcalu0_stall, mcalu1_stall,
        input  sched_scalu0_issue, sched_scalu1_issue,
        input  sched_mcalu0_issue, sched_mcalu1_issue,
        input  sched_scalu0_idx, sched_scalu1_idx,
        input  sched_mcalu0_idx, sched_mcalu1_idx,
        input  sched_free
    );

    modport slave (
        input  alloc_valid, alloc_idx, ent_ready, ent_mc, rob_flush,
        input  scalu0_stall, scalu1_stall, mcalu0_stall, mcalu1_stall,
        output sched_scalu0_issue, sched_scalu1_issue,
        output sched_mcalu0_issue, sched_mcalu1_issue,
        output sched_scalu0_idx, sched_scalu1_idx,
        output sched_mcalu0_idx, sched_mcalu1_idx,
        output sched_free
    );

endinterface

// File: rtl/exers_sched_pick.sv
// exers_sched_pick: age-matrix selector for one unit pool.
//   cand_i        : candidate entries (valid, unselected, ready, right class)
//   age_i[i][j]   : 1 when entry i is older than entry j
//   first_*_o     : oldest candidate
//   second_*_o    : oldest candidate once the first is removed
// A pick is only reported when exactly one entry qualifies as oldest, so a
// corrupted matrix yields no pick rather than an arbitrary one. Index
// outputs are zero whenever the matching valid is low.
module exers_sched_pick
    import exers_sched_pkg::*;
#(
    parameter int N = NENT_DEF,
    parameter int W = IDXW_DEF
) (
    input  logic [N-1:0]        cand_i,
    input  logic [N-1:0][N-1:0] age_i,
    output logic                first_vld_o,
    output logic [W-1:0]        first_idx_o,
    output logic                second_vld_o,
    output logic [W-1:0]        second_idx_o
);

    // Candidates that no other candidate is older than.
    function automatic logic [N-1:0] oldest(input logic [N-1:0]        c,
                                            input logic [N-1:0][N-1:0] a);
        logic [N-1:0] o;
        o = c;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (c[j] && a[j][i]) begin
                    o[i] = 1'b0;
                end
            end
        end
        return o;
    endfunction

    function automatic logic is_onehot(input logic [N-1:0] x);
        return (x != '0) && ((x & (x - N'(1))) == '0);
    endfunction

    function automatic logic [W-1:0] oh2idx(input logic [N-1:0] x);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                r = r | W'(i);
            end
        end
        return r;
    endfunction

    logic [N-1:0] first_oh_s;
    logic [N-1:0] rest_s;
    logic [N-1:0] second_oh_s;

    // Oldest and second-oldest selection.
    always_comb begin
        first_oh_s  = oldest(cand_i, age_i);
        first_vld_o = is_onehot(first_oh_s);
        rest_s      = cand_i & ~first_oh_s;
        second_oh_s = oldest(rest_s, age_i);
        if (first_vld_o) begin
            first_idx_o  = oh2idx(first_oh_s);
            second_vld_o = is_onehot(second_oh_s);
        end else begin
            first_idx_o  = '0;
            second_vld_o = 1'b0;
        end
        if (second_vld_o) begin
            second_idx_o = oh2idx(second_oh_s);
        end else begin
            second_idx_o = '0;
        end
    end

endmodule

// File: rtl/exers_sched.sv
// exers_sched: issue scheduler for the execute reservation stations.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : exers_sched_if.slave (alloc, per-entry ready/class, flush,
//              unit stalls in; four issue slots and free mask out)
// Keeps entry valid (V), entry-in-slot (S) and an age matrix, picks the
// oldest ready entries per pool and holds them in registered issue slots
// until the unit accepts (slot valid and no stall). Accepted entries are
// released and reported on sched_free the following cycle.
module exers_sched
    import exers_sched_pkg::*;
#(
    parameter int NENT = NENT_DEF,
    parameter int IDXW = IDXW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    exers_sched_if.slave bus
);

    logic [NENT-1:0]            v_q, v_d;
    logic [NENT-1:0]            s_q, s_d;
    logic [NENT-1:0][NENT-1:0]  age_q, age_d;
    logic [NENT-1:0]            free_q, free_d;
    logic [NSLOT-1:0]           slot_vld_q, slot_vld_d;
    logic [NSLOT-1:0][IDXW-1:0] slot_idx_q, slot_idx_d;

    logic [NSLOT-1:0]           stall_s;
    logic [NSLOT-1:0]           avail_s;
    logic [NSLOT-1:0]           ld_vld_s;
    logic [NSLOT-1:0][IDXW-1:0] ld_idx_s;
    logic [NENT-1:0]            elig_s;
    logic [NENT-1:0]            sc_cand_s;
    logic [NENT-1:0]            mc_cand_s;
    logic [NPOOL-1:0]           pk_fv_s;
    logic [NPOOL-1:0][IDXW-1:0] pk_fi_s;
    logic [NPOOL-1:0]           pk_sv_s;
    logic [NPOOL-1:0][IDXW-1:0] pk_si_s;

    assign stall_s = {bus.mcalu1_stall, bus.mcalu0_stall,
                      bus.scalu1_stall, bus.scalu0_stall};

    // Entries already sitting in a slot are not candidates again.
    assign elig_s = v_q & ~s_q & bus.ent_ready;

    // Split eligible entries into the SC and MC pools by unit class.
    always_comb begin
        sc_cand_s = '0;
        mc_cand_s = '0;
        for (int i = 0; i < NENT; i++) begin
            if (unit_cls_e'(bus.ent_mc[i]) == UC_MC) begin
                mc_cand_s[i] = elig_s[i];
            end else begin
                sc_cand_s[i] = elig_s[i];
            end
        end
    end

    exers_sched_pick #(.N(NENT), .W(IDXW)) u_pick_sc (
        .cand_i       (sc_cand_s),
        .age_i        (age_q),
        .first_vld_o  (pk_fv_s[0]),
        .first_idx_o  (pk_fi_s[0]),
        .second_vld_o (pk_sv_s[0]),
        .second_idx_o (pk_si_s[0])
    );

    exers_sched_pick #(.N(NENT), .W(IDXW)) u_pick_mc (
        .cand_i       (mc_cand_s),
        .age_i        (age_q),
        .first_vld_o  (pk_fv_s[1]),
        .first_idx_o  (pk_fi_s[1]),
        .second_vld_o (pk_sv_s[1]),
        .second_idx_o (pk_si_s[1])
    );

    // Route picks to slots: unit0 gets the oldest when free; otherwise the
    // oldest goes to unit1. When unit0 is free, unit1 takes the second pick
    // (only loaded if unit1 is free too).
    always_comb begin
        avail_s  = '0;
        ld_vld_s = '0;
        ld_idx_s = '0;
        for (int p = 0; p < NPOOL; p++) begin
            avail_s[2*p]   = ~slot_vld_q[2*p]   | ~stall_s[2*p];
            avail_s[2*p+1] = ~slot_vld_q[2*p+1] | ~stall_s[2*p+1];
            if (avail_s[2*p]) begin
                ld_vld_s[2*p]   = pk_fv_s[p];
                ld_idx_s[2*p]   = pk_fi_s[p];
                ld_vld_s[2*p+1] = pk_sv_s[p];
                ld_idx_s[2*p+1] = pk_si_s[p];
            end else begin
                ld_vld_s[2*p]   = 1'b0;
                ld_idx_s[2*p]   = '0;
                ld_vld_s[2*p+1] = pk_fv_s[p];
                ld_idx_s[2*p+1] = pk_fi_s[p];
            end
        end
    end

    // Next state: flush beats everything; otherwise accept, alloc, select.
    always_comb begin
        v_d        = v_q;
        s_d        = s_q;
        age_d      = age_q;
        free_d     = '0;
        slot_vld_d = slot_vld_q;
        slot_idx_d = slot_idx_q;
        if (bus.rob_flush) begin
            v_d        = '0;
            s_d        = '0;
            age_d      = '0;
            slot_vld_d = '0;
            slot_idx_d = '0;
        end else begin
            // Accepted slots release their entry.
            for (int k = 0; k < NSLOT; k++) begin
                if (slot_vld_q[k] && !stall_s[k]) begin
                    v_d[slot_idx_q[k]]    = 1'b0;
                    s_d[slot_idx_q[k]]    = 1'b0;
                    free_d[slot_idx_q[k]] = 1'b1;
                end else begin
                    free_d = free_d;
                end
            end
            // New entry is younger than every entry currently valid.
            if (bus.alloc_valid) begin
                v_d[bus.alloc_idx]   = 1'b1;
                s_d[bus.alloc_idx]   = 1'b0;
                age_d[bus.alloc_idx] = '0;
                for (int j = 0; j < NENT; j++) begin
                    if (IDXW'(j) != bus.alloc_idx) begin
                        age_d[j][bus.alloc_idx] = v_q[j];
                    end else begin
                        age_d[j][bus.alloc_idx] = 1'b0;
                    end
                end
            end else begin
                age_d = age_d;
            end
            // Free slots reload (possibly empty); stalled slots hold.
            for (int k = 0; k < NSLOT; k++) begin
                if (avail_s[k]) begin
                    slot_vld_d[k] = ld_vld_s[k];
                    slot_idx_d[k] = ld_idx_s[k];
                    if (ld_vld_s[k]) begin
                        s_d[ld_idx_s[k]] = 1'b1;
                    end else begin
                        s_d = s_d;
                    end
                end else begin
                    slot_vld_d[k] = slot_vld_q[k];
                    slot_idx_d[k] = slot_idx_q[k];
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q        <= '0;
            s_q        <= '0;
            age_q      <= '0;
            free_q     <= '0;
            slot_vld_q <= '0;
            slot_idx_q <= '0;
        end else begin
            v_q        <= v_d;
            s_q        <= s_d;
            age_q      <= age_d;
            free_q     <= free_d;
            slot_vld_q <= slot_vld_d;
            slot_idx_q <= slot_idx_d;
        end
    end

    assign bus.sched_scalu0_issue = slot_vld_q[SL_SC0];
    assign bus.sched_scalu1_issue = slot_vld_q[SL_SC1];
    assign bus.sched_mcalu0_issue = slot_vld_q[SL_MC0];
    assign bus.sched_mcalu1_issue = slot_vld_q[SL_MC1];
    assign bus.sched_scalu0_idx   = slot_idx_q[SL_SC0];
    assign bus.sched_scalu1_idx   = slot_idx_q[SL_SC1];
    assign bus.sched_mcalu0_idx   = slot_idx_q[SL_MC0];
    assign bus.sched_mcalu1_idx   = slot_idx_q[SL_MC1];
    assign bus.sched_free         = free_q;

endmodule

// File: tb/tb_exers_sched.sv
// tb_exers_sched: directed self-checking bench for exers_sched.
module tb_exers_sched;

    localparam int NENT = 8;
    localparam int IDXW = 3;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    logic [NENT-1:0] live;

    exers_sched_if #(.NENT(NENT), .IDXW(IDXW)) bus ();

    exers_sched #(.NENT(NENT), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // Packed as {issue[mc1,mc0,sc1,sc0], idx sc0, sc1, mc0, mc1 (4b each), free};
    // an idx is only compared where its slot is valid.
    task automatic chk_out(input string tag, input logic [3:0] iss,
                           input logic [2:0] i0, input logic [2:0] i1,
                           input logic [2:0] i2, input logic [2:0] i3,
                           input logic [7:0] fr);
        logic [3:0]  oi;
        logic [15:0] oidx;
        logic [15:0] eidx;
        oi   = {bus.sched_mcalu1_issue, bus.sched_mcalu0_issue,
                bus.sched_scalu1_issue, bus.sched_scalu0_issue};
        oidx = {oi[0]  ? {1'b0, bus.sched_scalu0_idx} : 4'h0,
                oi[1]  ? {1'b0, bus.sched_scalu1_idx} : 4'h0,
                oi[2]  ? {1'b0, bus.sched_mcalu0_idx} : 4'h0,
                oi[3]  ? {1'b0, bus.sched_mcalu1_idx} : 4'h0};
        eidx = {iss[0] ? {1'b0, i0} : 4'h0,
                iss[1] ? {1'b0, i1} : 4'h0,
                iss[2] ? {1'b0, i2} : 4'h0,
                iss[3] ? {1'b0, i3} : 4'h0};
        check(tag, {4'h0, oi, oidx, bus.sched_free}, {4'h0, iss, eidx, fr});
    endtask

    task automatic chk_idx_raw(input string tag);
        check(tag, {20'h0, bus.sched_scalu0_idx, bus.sched_scalu1_idx,
                    bus.sched_mcalu0_idx, bus.sched_mcalu1_idx}, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.alloc_valid = 1'b0;
        live = live & ~bus.sched_free;
    endtask

    task automatic do_alloc(input logic [2:0] idx, input logic mc, input logic rdy);
        if (live[idx]) begin
            $display("FAIL alloc_live: entry %0d still allocated", idx);
            $fatal(1, "illegal alloc");
        end else begin
            live[idx] = 1'b1;
        end
        bus.alloc_valid    = 1'b1;
        bus.alloc_idx      = idx;
        bus.ent_mc[idx]    = mc;
        bus.ent_ready[idx] = rdy;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        live = '0;
        rst = 1'b1;
        bus.alloc_valid  = 1'b0;
        bus.alloc_idx    = 3'd0;
        bus.ent_ready    = 8'h00;
        bus.ent_mc       = 8'h00;
        bus.rob_flush    = 1'b0;
        bus.scalu0_stall = 1'b0;
        bus.scalu1_stall = 1'b0;
        bus.mcalu0_stall = 1'b0;
        bus.mcalu1_stall = 1'b0;
        step();
        step();
        chk_out("rst_out", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        chk_idx_raw("rst_idx");
        rst = 1'b0;

        // Single SC entry: two-cycle latency, free the cycle after issue.
        do_alloc(3'd3, 1'b0, 1'b1);
        step();
        chk_out("t1_alloc", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        step();
        chk_out("t1_issue", 4'b0001, 3'd3, 3'd0, 3'd0, 3'd0, 8'h00);
        step();
        chk_out("t1_free", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h08);
        bus.ent_ready[3] = 1'b0;
        step();
        chk_out("t1_idle", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);

        // Age order 5, 2, 7; all ready together.
        do_alloc(3'd5, 1'b0, 1'b0);
        step();
        do_alloc(3'd2, 1'b0, 1'b0);
        step();
        do_alloc(3'd7, 1'b0, 1'b0);
        step();
        chk_out("t2_noready", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        bus.ent_ready = 8'hA4;
        step();
        chk_out("t2_pair", 4'b0011, 3'd5, 3'd2, 3'd0, 3'd0, 8'h00);
        step();
        chk_out("t2_b2b", 4'b0001, 3'd7, 3'd0, 3'd0, 3'd0, 8'h24);
        bus.ent_ready = 8'h00;
        step();
        chk_out("t2_last", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h80);

        // MC stall hold on mcalu0; second MC entry goes to mcalu1.
        do_alloc(3'd4, 1'b1, 1'b1);
        step();
        step();
        chk_out("t3_issue", 4'b0100, 3'd0, 3'd0, 3'd4, 3'd0, 8'h00);
        bus.mcalu0_stall = 1'b1;
        do_alloc(3'd6, 1'b1, 1'b1);
        step();
        chk_out("t3_hold1", 4'b0100, 3'd0, 3'd0, 3'd4, 3'd0, 8'h00);
        step();
        chk_out("t3_mc1", 4'b1100, 3'd0, 3'd0, 3'd4, 3'd6, 8'h00);
        step();
        chk_out("t3_hold3", 4'b0100, 3'd0, 3'd0, 3'd4, 3'd0, 8'h40);
        bus.mcalu0_stall = 1'b0;
        step();
        chk_out("t3_release", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h10);
        bus.ent_ready = 8'h00;
        bus.ent_mc    = 8'h00;

        // Older entry 1 not ready; younger 0 goes first.
        do_alloc(3'd1, 1'b0, 1'b0);
        step();
        do_alloc(3'd0, 1'b0, 1'b1);
        step();
        chk_out("t4_wait", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        step();
        chk_out("t4_young", 4'b0001, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        bus.ent_ready[1] = 1'b1;
        step();
        chk_out("t4_old", 4'b0001, 3'd1, 3'd0, 3'd0, 3'd0, 8'h01);
        bus.ent_ready = 8'h00;
        step();
        chk_out("t4_free", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h02);

        // Independent pools: SC 2 and MC 3 issue together.
        do_alloc(3'd2, 1'b0, 1'b0);
        step();
        do_alloc(3'd3, 1'b1, 1'b0);
        step();
        chk_out("t5_wait", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        bus.ent_ready = 8'h0C;
        step();
        chk_out("t5_mixed", 4'b0101, 3'd2, 3'd0, 3'd3, 3'd0, 8'h00);
        bus.ent_ready = 8'h00;
        step();
        chk_out("t5_free", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h0C);

        // All four slots valid, then flush with a same-cycle alloc.
        do_alloc(3'd0, 1'b0, 1'b0);
        step();
        do_alloc(3'd1, 1'b0, 1'b0);
        step();
        do_alloc(3'd2, 1'b1, 1'b0);
        step();
        do_alloc(3'd3, 1'b1, 1'b0);
        step();
        bus.ent_ready = 8'h0F;
        step();
        chk_out("t6_full", 4'b1111, 3'd0, 3'd1, 3'd2, 3'd3, 8'h00);
        bus.rob_flush = 1'b1;
        do_alloc(3'd5, 1'b0, 1'b1);
        step();
        live = '0;
        chk_out("t6_flush", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        bus.rob_flush = 1'b0;
        step();
        chk_out("t6_empty", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        bus.ent_ready = 8'h00;
        do_alloc(3'd6, 1'b0, 1'b1);
        step();
        chk_out("t6_post_alloc", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        step();
        chk_out("t6_post_issue", 4'b0001, 3'd6, 3'd0, 3'd0, 3'd0, 8'h00);
        step();
        chk_out("t6_post_free", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h40);

        // Asynchronous reset in the middle of a cycle.
        do_alloc(3'd4, 1'b0, 1'b1);
        step();
        step();
        chk_out("t7_pre", 4'b0001, 3'd4, 3'd0, 3'd0, 3'd0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t7_async", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
        chk_idx_raw("t7_async_idx");
        step();
        rst = 1'b0;
        live = '0;
        bus.ent_ready = 8'h00;
        step();
        chk_out("t7_after", 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
